// File: rtl/pipeline_stage_ctrl.sv
// pipeline_stage_ctrl: five-stage inst/pc/valid pipeline registers with
// load-use stall, taken-branch flush and saturating stall/flush event counters.
module pipeline_stage_ctrl #(
    parameter int XLEN = 32,
    parameter int CNT_W = 16,
    parameter logic [XLEN-1:0] NOP_INST = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  fetch_inst,
    input  logic [XLEN-1:0]  fetch_pc,
    input  logic             fetch_valid,
    input  logic             stallF_req,
    input  logic             br_taken_X,
    output logic [XLEN-1:0]  instF,
    output logic [XLEN-1:0]  instD,
    output logic [XLEN-1:0]  instX,
    output logic [XLEN-1:0]  instM,
    output logic [XLEN-1:0]  instW,
    output logic [XLEN-1:0]  pcF,
    output logic [XLEN-1:0]  pcD,
    output logic [XLEN-1:0]  pcX,
    output logic [XLEN-1:0]  pcM,
    output logic [XLEN-1:0]  pcW,
    output logic             validF,
    output logic             validD,
    output logic             validX,
    output logic             validM,
    output logic             validW,
    output logic             pc_en,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic flush, stall, bubble_d;

    assign flush    = br_taken_X & validX;
    assign stall    = stallF_req & validF & ~flush;
    assign bubble_d = flush | stall;
    assign pc_en    = ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instF     <= NOP_INST;
            instD     <= NOP_INST;
            instX     <= NOP_INST;
            instM     <= NOP_INST;
            instW     <= NOP_INST;
            pcF       <= '0;
            pcD       <= '0;
            pcX       <= '0;
            pcM       <= '0;
            pcW       <= '0;
            validF    <= 1'b0;
            validD    <= 1'b0;
            validX    <= 1'b0;
            validM    <= 1'b0;
            validW    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            instW  <= instM;
            pcW    <= pcM;
            validW <= validM;
            instM  <= instX;
            pcM    <= pcX;
            validM <= validX;
            instX  <= flush ? NOP_INST : instD;
            pcX    <= pcD;
            validX <= validD & ~flush;
            instD  <= bubble_d ? NOP_INST : instF;
            pcD    <= pcF;
            validD <= validF & ~bubble_d;
            // F holds only on stall; a flush reloads it with the redirected fetch
            if (!stall) begin
                instF  <= fetch_valid ? fetch_inst : NOP_INST;
                pcF    <= fetch_pc;
                validF <= fetch_valid;
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// tb_pipeline_stage_ctrl: table-driven per-cycle vectors plus an in-order
// retirement scoreboard at W, then reset and counter-saturation sequences.
module tb_pipeline_stage_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] TAG = 32'hA0000000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fetch_inst = '0, fetch_pc = '0;
    logic        fetch_valid = 1'b0, stallF_req = 1'b0, br_taken_X = 1'b0;
    logic [31:0] instF, instD, instX, instM, instW;
    logic [31:0] pcF, pcD, pcX, pcM, pcW;
    logic        validF, validD, validX, validM, validW, pc_en;
    logic [3:0]  stall_cnt, flush_cnt;

    pipeline_stage_ctrl #(.XLEN(32), .CNT_W(4), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
        .stallF_req(stallF_req), .br_taken_X(br_taken_X),
        .instF(instF), .instD(instD), .instX(instX), .instM(instM), .instW(instW),
        .pcF(pcF), .pcD(pcD), .pcX(pcX), .pcM(pcM), .pcW(pcW),
        .validF(validF), .validD(validD), .validX(validX), .validM(validM), .validW(validW),
        .pc_en(pc_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        s, b, en, vf;
        logic [31:0] pcf;
        logic        vd;
        logic [31:0] pcd;
        logic        vx;
        logic [31:0] pcx;
        int          sc, fc;
        logic        ret;
    } vec_t;

    vec_t        tbl[17];
    logic [31:0] sb[$];
    logic [31:0] e;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valids"}, {27'd0, validF, validD, validX, validM, validW}, 32'd0);
        chk({tag, "_instF"}, instF, NOP);
        chk({tag, "_instD"}, instD, NOP);
        chk({tag, "_instX"}, instX, NOP);
        chk({tag, "_instM"}, instM, NOP);
        chk({tag, "_instW"}, instW, NOP);
        chk({tag, "_pcs"}, pcF | pcD | pcX | pcM | pcW, 32'd0);
        chk({tag, "_cnts"}, {24'd0, stall_cnt, flush_cnt}, 32'd0);
    endtask

    initial begin
        //          fv  fpc        s  b  en vf pcF        vD pcD        vX pcX        sc fc ret
        tbl[0]  = '{1, 32'h000, 0, 0, 1, 1, 32'h000, 0, 32'h000, 0, 32'h000, 0, 0, 1};
        tbl[1]  = '{1, 32'h004, 0, 0, 1, 1, 32'h004, 1, 32'h000, 0, 32'h000, 0, 0, 1};
        tbl[2]  = '{1, 32'h008, 0, 0, 1, 1, 32'h008, 1, 32'h004, 1, 32'h000, 0, 0, 1};
        tbl[3]  = '{1, 32'h00C, 1, 0, 0, 1, 32'h008, 0, 32'h000, 1, 32'h004, 1, 0, 0};
        tbl[4]  = '{1, 32'h00C, 0, 0, 1, 1, 32'h00C, 1, 32'h008, 0, 32'h000, 1, 0, 0};
        tbl[5]  = '{1, 32'h010, 1, 1, 0, 1, 32'h00C, 0, 32'h000, 1, 32'h008, 2, 0, 0};
        tbl[6]  = '{1, 32'h200, 0, 1, 1, 1, 32'h200, 0, 32'h000, 0, 32'h000, 2, 1, 1};
        tbl[7]  = '{1, 32'h204, 0, 0, 1, 1, 32'h204, 1, 32'h200, 0, 32'h000, 2, 1, 0};
        tbl[8]  = '{1, 32'h208, 0, 0, 1, 1, 32'h208, 1, 32'h204, 1, 32'h200, 2, 1, 0};
        tbl[9]  = '{1, 32'h300, 1, 1, 1, 1, 32'h300, 0, 32'h000, 0, 32'h000, 2, 2, 1};
        tbl[10] = '{0, 32'h304, 0, 0, 1, 0, 32'h304, 1, 32'h300, 0, 32'h000, 2, 2, 0};
        tbl[11] = '{1, 32'h400, 1, 0, 1, 1, 32'h400, 0, 32'h000, 1, 32'h300, 2, 2, 1};
        tbl[12] = '{1, 32'h404, 0, 0, 1, 1, 32'h404, 1, 32'h400, 0, 32'h000, 2, 2, 1};
        tbl[13] = '{0, 32'h000, 0, 0, 1, 0, 32'h000, 1, 32'h404, 1, 32'h400, 2, 2, 0};
        tbl[14] = '{0, 32'h000, 0, 0, 1, 0, 32'h000, 0, 32'h000, 1, 32'h404, 2, 2, 0};
        tbl[15] = '{0, 32'h000, 0, 0, 1, 0, 32'h000, 0, 32'h000, 0, 32'h000, 2, 2, 0};
        tbl[16] = '{0, 32'h000, 0, 0, 1, 0, 32'h000, 0, 32'h000, 0, 32'h000, 2, 2, 0};

        repeat (2) @(posedge clk);
        #1 chk_reset("init");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            fetch_valid = tbl[i].fv;
            fetch_pc    = tbl[i].fpc;
            fetch_inst  = TAG | tbl[i].fpc;
            stallF_req  = tbl[i].s;
            br_taken_X  = tbl[i].b;
            if (tbl[i].ret) sb.push_back(tbl[i].fpc);
            #1 chk($sformatf("r%0d_pc_en", i), {31'd0, pc_en}, {31'd0, tbl[i].en});
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_validF", i), {31'd0, validF}, {31'd0, tbl[i].vf});
            chk($sformatf("r%0d_pcF", i), pcF, tbl[i].pcf);
            chk($sformatf("r%0d_instF", i), instF, tbl[i].vf ? (TAG | tbl[i].pcf) : NOP);
            chk($sformatf("r%0d_validD", i), {31'd0, validD}, {31'd0, tbl[i].vd});
            if (tbl[i].vd) chk($sformatf("r%0d_pcD", i), pcD, tbl[i].pcd);
            if (!tbl[i].vd) chk($sformatf("r%0d_instD", i), instD, NOP);
            chk($sformatf("r%0d_validX", i), {31'd0, validX}, {31'd0, tbl[i].vx});
            if (tbl[i].vx) chk($sformatf("r%0d_pcX", i), pcX, tbl[i].pcx);
            if (!tbl[i].vx) chk($sformatf("r%0d_instX", i), instX, NOP);
            chk($sformatf("r%0d_stall_cnt", i), {28'd0, stall_cnt}, tbl[i].sc);
            chk($sformatf("r%0d_flush_cnt", i), {28'd0, flush_cnt}, tbl[i].fc);
            if (validW) begin
                if (sb.size() == 0) chk($sformatf("r%0d_sb_unexpected_pcW", i), pcW, 32'hFFFFFFFF);
                else begin
                    e = sb.pop_front();
                    chk($sformatf("r%0d_sb_pcW", i), pcW, e);
                    chk($sformatf("r%0d_sb_instW", i), instW, TAG | e);
                end
            end
        end
        chk("sb_empty", sb.size(), 32'd0);

        // asynchronous reset in the middle of a stall cycle
        fetch_valid = 1'b1; fetch_pc = 32'h500; fetch_inst = TAG | 32'h500;
        stallF_req = 1'b0; br_taken_X = 1'b0;
        repeat (3) @(posedge clk);
        stallF_req = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clk);
        stallF_req = 1'b0; fetch_pc = 32'h100; fetch_inst = TAG | 32'h100;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_validF", {31'd0, validF}, 32'd1);
        chk("rel_pcF", pcF, 32'h100);
        chk("rel_validD", {31'd0, validD}, 32'd0);

        // held stall: F frozen, counter saturates at 15
        stallF_req = 1'b1;
        fetch_pc = 32'h104; fetch_inst = TAG | 32'h104;
        #1 chk("sat_pc_en", {31'd0, pc_en}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("sat_stall_cnt", {28'd0, stall_cnt}, 32'd15);
        chk("sat_pcF", pcF, 32'h100);
        chk("sat_validD", {31'd0, validD}, 32'd0);
        chk("sat_flush_cnt", {28'd0, flush_cnt}, 32'd0);
        stallF_req = 1'b0; fetch_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("fv0_validF", {31'd0, validF}, 32'd0);
        chk("fv0_instF", instF, NOP);
        chk("fv0_validD", {31'd0, validD}, 32'd1);
        chk("fv0_stall_cnt", {28'd0, stall_cnt}, 32'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
